// File: rtl/wvb_reader_if.sv
// rtl/wvb_reader_if.sv - 16-bit readout word stream from wvb_reader to the readout/DMA path
interface wvb_reader_if;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  modport master (output dout, output dout_valid, output dout_last, input dout_ready);
  modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/wvb_reader.sv
// rtl/wvb_reader.sv - waveform buffer readout: pops a header, emits a 6-word event header, then serialized samples
// Defining WVB_READER_CRC_EN appends a CRC-16-CCITT word to every event.
module wvb_reader #(
  parameter int P_DATA_WIDTH = 22,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 160,
  parameter int P_LTC_WIDTH  = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic                    wvb_rdreq,
  output logic                    wvb_rddone,
  wvb_reader_if.master            dout_if,
  output logic                    busy,
  output logic                    len_err,
  output logic [15:0]             n_evt_read
);
  localparam int L_START = P_LTC_WIDTH;
  localparam int L_STOP  = L_START + P_ADR_WIDTH;
  localparam int L_TRIG  = L_STOP + P_ADR_WIDTH;
  localparam int L_CNST  = L_TRIG + 2;
  localparam int L_EOE   = P_DATA_WIDTH - 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_RD, ST_WAIT, ST_S_HI, ST_S_LO, ST_DONE
`ifdef WVB_READER_CRC_EN
    , ST_CRC
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              widx_q, widx_d;
  logic [P_ADR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [P_ADR_WIDTH-1:0]  evt_len_q, evt_len_d;
  logic [P_LTC_WIDTH-1:0]  ltc_q, ltc_d;
  logic [1:0]              trig_q, trig_d;
  logic                    cnst_q, cnst_d;
  logic [P_DATA_WIDTH-1:0] sample_q, sample_d;
  logic                    hdr_rdreq_q, hdr_rdreq_d;
  logic                    len_err_q, len_err_d;
  logic [15:0]             n_evt_q, n_evt_d;
`ifdef WVB_READER_CRC_EN
  logic [15:0]             crc_q, crc_d;
`endif

  logic [15:0] word_w;
  logic        valid_w, last_w, accept, last_smp;
  logic        unused_hdr;

  assign unused_hdr = ^hdr_data[P_HDR_WIDTH-1:L_CNST+1];
  assign accept     = valid_w & dout_if.dout_ready;
  // A sample closes the event either on its eoe flag or when the length runs out.
  assign last_smp   = sample_q[L_EOE] | (cnt_q == '0);

`ifdef WVB_READER_CRC_EN
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ w[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      cnt_q       <= '0;
      evt_len_q   <= '0;
      ltc_q       <= '0;
      trig_q      <= '0;
      cnst_q      <= 1'b0;
      sample_q    <= '0;
      hdr_rdreq_q <= 1'b0;
      len_err_q   <= 1'b0;
      n_evt_q     <= '0;
`ifdef WVB_READER_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      cnt_q       <= cnt_d;
      evt_len_q   <= evt_len_d;
      ltc_q       <= ltc_d;
      trig_q      <= trig_d;
      cnst_q      <= cnst_d;
      sample_q    <= sample_d;
      hdr_rdreq_q <= hdr_rdreq_d;
      len_err_q   <= len_err_d;
      n_evt_q     <= n_evt_d;
`ifdef WVB_READER_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    cnt_d       = cnt_q;
    evt_len_d   = evt_len_q;
    ltc_d       = ltc_q;
    trig_d      = trig_q;
    cnst_d      = cnst_q;
    sample_d    = sample_q;
    hdr_rdreq_d = 1'b0;
    len_err_d   = len_err_q;
    n_evt_d     = n_evt_q;
`ifdef WVB_READER_CRC_EN
    crc_d       = crc_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rd_en && !hdr_empty) begin
          ltc_d       = hdr_data[P_LTC_WIDTH-1:0];
          evt_len_d   = hdr_data[L_STOP +: P_ADR_WIDTH] - hdr_data[L_START +: P_ADR_WIDTH];
          cnt_d       = hdr_data[L_STOP +: P_ADR_WIDTH] - hdr_data[L_START +: P_ADR_WIDTH];
          trig_d      = hdr_data[L_TRIG +: 2];
          cnst_d      = hdr_data[L_CNST];
          widx_d      = '0;
          hdr_rdreq_d = 1'b1;
`ifdef WVB_READER_CRC_EN
          crc_d       = 16'hFFFF;
`endif
          state_d     = ST_HDR;
        end
      end
      ST_HDR: begin
        if (accept) begin
          widx_d = widx_q + 3'd1;
          if (widx_q == 3'd5) state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: begin
        sample_d = wvb_data;
        state_d  = ST_S_HI;
      end
      ST_S_HI: if (accept) state_d = ST_S_LO;
      ST_S_LO: begin
        if (accept) begin
          if (last_smp) begin
            if (sample_q[L_EOE] != (cnt_q == '0)) len_err_d = 1'b1;
`ifdef WVB_READER_CRC_EN
            state_d = ST_CRC;
`else
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d   = cnt_q - P_ADR_WIDTH'(1);
            state_d = ST_RD;
          end
        end
      end
`ifdef WVB_READER_CRC_EN
      ST_CRC: if (accept) state_d = ST_DONE;
`endif
      ST_DONE: begin
        n_evt_d = n_evt_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef WVB_READER_CRC_EN
    // The CRC word itself is not folded into the running CRC.
    if (accept && state_q != ST_CRC) crc_d = crc16_word(crc_q, word_w);
`endif
  end

  always_comb begin
    word_w     = '0;
    valid_w    = 1'b0;
    last_w     = 1'b0;
    wvb_rdreq  = 1'b0;
    wvb_rddone = 1'b0;
    unique case (state_q)
      ST_HDR: begin
        valid_w = 1'b1;
        case (widx_q)
          3'd0:    word_w = 16'hEB90;
          3'd1:    word_w = 16'(evt_len_q);
          3'd2:    word_w = ltc_q[47:32];
          3'd3:    word_w = ltc_q[31:16];
          3'd4:    word_w = ltc_q[15:0];
          default: word_w = {13'b0, cnst_q, trig_q};
        endcase
      end
      ST_RD: wvb_rdreq = 1'b1;
      ST_S_HI: begin
        valid_w = 1'b1;
        word_w  = {sample_q[20], sample_q[L_EOE], 6'b0, sample_q[19:12]};
      end
      ST_S_LO: begin
        valid_w = 1'b1;
        word_w  = {4'h0, sample_q[11:0]};
`ifndef WVB_READER_CRC_EN
        last_w  = last_smp;
`endif
      end
`ifdef WVB_READER_CRC_EN
      ST_CRC: begin
        valid_w = 1'b1;
        word_w  = crc_q;
        last_w  = 1'b1;
      end
`endif
      ST_DONE: wvb_rddone = 1'b1;
      default: ;
    endcase
  end

  assign dout_if.dout       = word_w;
  assign dout_if.dout_valid = valid_w;
  assign dout_if.dout_last  = last_w;
  assign hdr_rdreq          = hdr_rdreq_q;
  assign busy               = (state_q != ST_IDLE);
  assign len_err            = len_err_q;
  assign n_evt_read         = n_evt_q;
endmodule
